pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-sequencing controller that owns the 8-bit program counter and decides its next value each `sysclk` cycle. It supports sequential increment, stalls, absolute jumps, signed relative branches, and call/return through a small hardware return stack. It sits between the decoder (redirect requests) and instruction memory (valid/ready fetch handshake), and replaces the free-running counter with a controlled one.

## Interface

Parameters:
- `PC_W`, 8: program counter width.
- `STACK_DEPTH`, 4: return-stack entries.
- `RESET_VEC`, 8'h00: PC value after reset.

Ports:
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `sysrst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  start/resume pulse; acted on in IDLE or HALTED.
- `halt_req`  in  1  stop fetching; acted on in FETCH.
- `stall`  in  1  hold the PC and deassert `fetch_valid`.
- `fetch_ready`  in  1  instruction memory accepts the current `pc`.
- `br_valid`  in  1  redirect request from the decoder.
- `br_op`  in  2  redirect type: 0 JUMP (absolute), 1 BRANCH (relative), 2 CALL, 3 RET.
- `br_target`  in  PC_W  absolute target, or signed two's-complement offset for BRANCH.
- `pc`  out  PC_W  current fetch address; registered.
- `fetch_valid`  out  1  `pc` is a valid fetch request.
- `running`  out  1  high when the FSM is in FETCH.
- `stack_err`  out  1  sticky overflow/underflow flag.

## Operation

- FSM states: IDLE, FETCH, HALTED.
  - IDLE: `run` moves to FETCH.
  - FETCH: `halt_req` moves to HALTED.
  - HALTED: `run` moves to FETCH and resumes from the held `pc`.
- `fetch_valid` = (state == FETCH) && !`stall`, combinational. `running` = (state == FETCH).
- In FETCH, the next PC is chosen by this priority:
  1. `br_valid`: the redirect is taken, even if `stall` or `fetch_ready` is asserted. A same-cycle handshake is flushed, so no increment happens.
  2. `stall`: `pc` holds.
  3. `fetch_valid && fetch_ready`: `pc <= pc + 1`.
  4. Otherwise `pc` holds.
- Redirect results:
  - JUMP: `pc <= br_target`.
  - BRANCH: `pc <= pc + br_target`, with `br_target` sign-extended and the result taken mod 2^PC_W.
  - CALL: push `pc + 1`, then `pc <= br_target`.
  - RET: pop the top entry into `pc`.
- Arithmetic is PC_W bits and wraps: 8'hFF + 1 = 8'h00; 8'h02 + (−3) = 8'hFF.
- CALL with the stack full: the push is dropped, the jump is still taken, and `stack_err` is set.
- RET with the stack empty: `pc <= pc + 1` and `stack_err` is set.
- `stack_err` clears only on reset.
- `br_valid`, `halt_req` and `stall` are ignored outside FETCH. `run` is ignored in FETCH.
- `halt_req` together with `br_valid` in the same cycle: the redirect updates `pc`, then the FSM enters HALTED.

## Timing

- Reset (asynchronous, takes effect immediately on `sysrst_n` low):
  - state = IDLE, `pc` = RESET_VEC, `fetch_valid` = 0, `running` = 0, `stack_err` = 0, stack empty.
- Reset mid-operation discards any pending handshake and all stack contents.
- A new `pc` is visible in the cycle after the deciding edge; a redirect has 1-cycle latency.
- `run` in IDLE at edge N: `fetch_valid` = 1 in cycle N+1, with `pc` = RESET_VEC.
- Handshake: one address is consumed per cycle in which `fetch_valid && fetch_ready`. Back-to-back fetches sustain 1 address per cycle.
- `halt_req` at edge N: `fetch_valid` = 0 from cycle N+1. A handshake in cycle N still completes and increments `pc`.

## Structure

- Shared package `pc_pkg`:
  - `PC_W` default.
  - `br_op` encodings (`OP_JUMP`, `OP_BRANCH`, `OP_CALL`, `OP_RET`).
  - FSM state enum.
- Sub-module `pc_return_stack`, a LIFO of STACK_DEPTH × PC_W:
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout`, `full`, `empty`.
  - Asynchronous active-low clear.
  - Overflow and underflow are reported to the parent, which sets `stack_err`.
- Top level: the FSM, the next-PC mux/adder and `stack_err`.

## Test plan

- Reset, pulse `run`, `fetch_ready` = 1 for 3 cycles -> `pc` 00, 01, 02, 03; `fetch_valid` = 1 from the cycle after `run`.
- JUMP to FF, then one handshake -> `pc` = 00 (wrap). At `pc` = 10, BRANCH with `br_target` = 8'hFD (−3) -> `pc` = 0D.
- `stall` = 1 with `fetch_ready` = 1 for 4 cycles -> `pc` holds and `fetch_valid` = 0. `br_valid` JUMP 20 during `stall` -> `pc` = 20.
- At `pc` = 05, CALL 40, then RET -> `pc` 40, then 06. Five nested CALLs with depth 4 -> `stack_err` = 1; five RETs then a sixth RET -> `stack_err` stays 1 and the sixth RET yields `pc + 1`.
- `halt_req` and JUMP 30 in the same cycle -> HALTED, `pc` = 30, `fetch_valid` = 0. `run` -> FETCH resumes at 30.
- Assert `sysrst_n` low mid-FETCH between clock edges -> `pc` = 00, `fetch_valid` = 0, `stack_err` = 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the fetch sequencer. Holds the default
//               PC width and return-stack depth, the redirect opcode
//               encodings and the sequencer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 4;

    // Redirect opcodes carried on br_op
    localparam logic [1:0] OP_JUMP   = 2'd0;
    localparam logic [1:0] OP_BRANCH = 2'd1;
    localparam logic [1:0] OP_CALL   = 2'd2;
    localparam logic [1:0] OP_RET    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_return_stack
// Description : LIFO of STACK_DEPTH x PC_W return addresses.
//   sysclk, sysrst_n : clock, asynchronous active-low clear (empties stack)
//   push, din        : write din on top (dropped when full)
//   pop              : discard the top entry (ignored when empty)
//   dout             : current top entry (zero when empty)
//   full, empty      : occupancy flags
//   overflow         : push attempted while full (this cycle)
//   underflow        : pop attempted while empty (this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic            sysclk,
    input  logic            sysrst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);

    localparam int c_PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(STACK_DEPTH + 1);

    logic [c_CNT_W-1:0] r_count;
    logic [PC_W-1:0]    r_mem [STACK_DEPTH];
    logic [c_CNT_W-1:0] w_top;

    assign w_top     = r_count - c_CNT_W'(1);
    assign full      = (r_count == c_CNT_W'(STACK_DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = empty ? '0 : r_mem[w_top[c_PTR_W-1:0]];
    assign overflow  = push && full;
    assign underflow = pop && empty;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !full) begin
            r_mem[r_count[c_PTR_W-1:0]] <= din;
            r_count                     <= r_count + c_CNT_W'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

endmodule : pc_return_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the program counter. IDLE/FETCH/HALTED FSM, next-PC
//               selection (redirect > stall > handshake increment > hold),
//               return stack for CALL/RET and a sticky stack error flag.
//   sysclk, sysrst_n : clock, asynchronous active-low reset
//   run, halt_req    : start/resume and stop requests
//   stall            : hold pc, suppress fetch_valid
//   fetch_ready      : instruction memory accepts pc
//   br_valid/op/target : redirect request from the decoder
//   pc, fetch_valid  : registered fetch address and its qualifier
//   running          : FSM is in FETCH
//   stack_err        : sticky return-stack overflow/underflow
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter int              STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input  logic            sysclk,
    input  logic            sysrst_n,
    input  logic            run,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            br_valid,
    input  logic [1:0]      br_op,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            running,
    output logic            stack_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic            r_stack_err;
    logic            w_push;
    logic            w_pop;
    logic [PC_W-1:0] w_stk_dout;
    logic            w_stk_full;
    logic            w_stk_empty;
    logic            w_stk_ovf;
    logic            w_stk_unf;

    assign w_pc_inc    = r_pc + PC_W'(1);
    assign pc          = r_pc;
    assign running     = (r_state == ST_FETCH);
    assign fetch_valid = (r_state == ST_FETCH) && !stall;
    assign stack_err   = r_stack_err;

    pc_return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .sysclk    (sysclk),
        .sysrst_n  (sysrst_n),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_pc_inc),
        .dout      (w_stk_dout),
        .full      (w_stk_full),
        .empty     (w_stk_empty),
        .overflow  (w_stk_ovf),
        .underflow (w_stk_unf)
    );

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VEC;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_stack_err <= r_stack_err | w_stk_ovf | w_stk_unf;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // Halt only changes state; pc still follows the normal
                // priority, so a same-cycle redirect or handshake lands.
                if (halt_req) w_state_nxt = ST_HALTED;
                if (br_valid) begin
                    case (br_op)
                        OP_JUMP:   w_pc_nxt = br_target;
                        // Same-width add equals sign-extended add mod 2^PC_W.
                        OP_BRANCH: w_pc_nxt = r_pc + br_target;
                        OP_CALL: begin
                            w_push   = 1'b1;     // dropped by the stack if full
                            w_pc_nxt = br_target;
                        end
                        default: begin           // OP_RET
                            w_pop    = 1'b1;     // flagged as underflow if empty
                            w_pc_nxt = w_stk_empty ? w_pc_inc : w_stk_dout;
                        end
                    endcase
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (fetch_ready) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            ST_HALTED: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Expected
//               {pc, fetch_valid, running, stack_err} tuples are queued when
//               each step's stimulus is applied and popped after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic       sysclk = 1'b0;
    logic       sysrst_n;
    logic       run, halt_req, stall, fetch_ready, br_valid;
    logic [1:0] br_op;
    logic [7:0] br_target;
    logic [7:0] pc;
    logic       fetch_valid, running, stack_err;

    int tests = 0;
    int fails = 0;

    string       q_tag [$];
    logic [10:0] q_exp [$];

    always #5 sysclk = ~sysclk;

    pc_sequencer #(
        .PC_W        (8),
        .STACK_DEPTH (4),
        .RESET_VEC   (8'h00)
    ) dut (
        .sysclk      (sysclk),
        .sysrst_n    (sysrst_n),
        .run         (run),
        .halt_req    (halt_req),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .br_valid    (br_valid),
        .br_op       (br_op),
        .br_target   (br_target),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .running     (running),
        .stack_err   (stack_err)
    );

    task automatic push_exp(input string tag, input logic [7:0] epc,
                            input logic efv, input logic erun, input logic eerr);
        q_tag.push_back(tag);
        q_exp.push_back({epc, efv, erun, eerr});
    endtask

    task automatic check_head();
        string       tag;
        logic [10:0] exp;
        logic [10:0] obs;
        tag = q_tag.pop_front();
        exp = q_exp.pop_front();
        obs = {pc, fetch_valid, running, stack_err};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got pc=%h fv=%b run=%b err=%b, want pc=%h fv=%b run=%b err=%b",
                   tag, obs[10:3], obs[2], obs[1], obs[0],
                   exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock step: queue expectation, take the edge, compare 1ns later.
    task automatic cyc(input string tag, input logic [7:0] epc,
                       input logic efv, input logic erun, input logic eerr);
        push_exp(tag, epc, efv, erun, eerr);
        @(posedge sysclk);
        #1;
        check_head();
    endtask

    task automatic redirect(input logic [1:0] op, input logic [7:0] tgt);
        br_valid  = 1'b1;
        br_op     = op;
        br_target = tgt;
    endtask

    initial begin
        sysrst_n = 1'b0; run = 0; halt_req = 0; stall = 0; fetch_ready = 0;
        br_valid = 0; br_op = 2'd0; br_target = 8'h00;
        #3;
        push_exp("reset", 8'h00, 0, 0, 0);
        check_head();
        @(posedge sysclk); #1;
        sysrst_n = 1'b1;
        cyc("idle_hold", 8'h00, 0, 0, 0);

        // Start and sequential fetch
        run = 1;
        cyc("run", 8'h00, 1, 1, 0);
        run = 0; fetch_ready = 1;
        cyc("inc1", 8'h01, 1, 1, 0);
        cyc("inc2", 8'h02, 1, 1, 0);
        cyc("inc3", 8'h03, 1, 1, 0);
        fetch_ready = 0;
        cyc("no_ready_hold", 8'h03, 1, 1, 0);

        // Jump with wrap, relative branch backwards
        redirect(2'd0, 8'hFF);
        cyc("jump_ff", 8'hFF, 1, 1, 0);
        br_valid = 0; fetch_ready = 1;
        cyc("wrap", 8'h00, 1, 1, 0);
        redirect(2'd0, 8'h10);
        cyc("jump_10", 8'h10, 1, 1, 0);
        redirect(2'd1, 8'hFD);
        cyc("branch_m3", 8'h0D, 1, 1, 0);
        redirect(2'd0, 8'h02);
        cyc("jump_02", 8'h02, 1, 1, 0);
        redirect(2'd1, 8'hFD);
        cyc("branch_wrap", 8'hFF, 1, 1, 0);
        redirect(2'd0, 8'h0D);
        cyc("jump_0d", 8'h0D, 1, 1, 0);
        br_valid = 0;

        // Stall with ready held, then redirect during stall
        stall = 1;
        for (int i = 0; i < 4; i++) cyc("stall_hold", 8'h0D, 0, 1, 0);
        redirect(2'd0, 8'h20);
        cyc("jump_in_stall", 8'h20, 0, 1, 0);
        br_valid = 0; stall = 0; fetch_ready = 0;
        cyc("unstall", 8'h20, 1, 1, 0);

        // CALL / RET
        redirect(2'd0, 8'h05);
        cyc("jump_05", 8'h05, 1, 1, 0);
        redirect(2'd2, 8'h40);
        cyc("call_40", 8'h40, 1, 1, 0);
        redirect(2'd3, 8'h00);
        cyc("ret_06", 8'h06, 1, 1, 0);
        // Five nested calls: return addresses 07,51,52,53 then overflow
        redirect(2'd2, 8'h50); cyc("call_n1", 8'h50, 1, 1, 0);
        redirect(2'd2, 8'h51); cyc("call_n2", 8'h51, 1, 1, 0);
        redirect(2'd2, 8'h52); cyc("call_n3", 8'h52, 1, 1, 0);
        redirect(2'd2, 8'h53); cyc("call_n4", 8'h53, 1, 1, 0);
        redirect(2'd2, 8'h54); cyc("call_ovf", 8'h54, 1, 1, 1);
        redirect(2'd3, 8'h00); cyc("ret_n1", 8'h53, 1, 1, 1);
        cyc("ret_n2", 8'h52, 1, 1, 1);
        cyc("ret_n3", 8'h51, 1, 1, 1);
        cyc("ret_n4", 8'h07, 1, 1, 1);
        cyc("ret_empty1", 8'h08, 1, 1, 1);
        cyc("ret_empty2", 8'h09, 1, 1, 1);
        br_valid = 0;

        // Halt together with jump; HALTED ignores redirects; resume
        halt_req = 1; redirect(2'd0, 8'h30);
        cyc("halt_jump", 8'h30, 0, 0, 1);
        halt_req = 0; redirect(2'd0, 8'h77); fetch_ready = 1;
        cyc("halted_ignore", 8'h30, 0, 0, 1);
        br_valid = 0; fetch_ready = 0; run = 1;
        cyc("resume", 8'h30, 1, 1, 1);
        run = 0; fetch_ready = 1;
        cyc("resume_inc", 8'h31, 1, 1, 1);
        halt_req = 1;
        cyc("halt_hs", 8'h32, 0, 0, 1);
        halt_req = 0; fetch_ready = 0; run = 1;
        cyc("resume2", 8'h32, 1, 1, 1);
        run = 0;

        // Push one entry, then async reset between edges
        redirect(2'd2, 8'h60);
        cyc("call_pre_rst", 8'h60, 1, 1, 1);
        br_valid = 0; fetch_ready = 1;
        #2;
        sysrst_n = 1'b0;
        #1;
        push_exp("async_reset", 8'h00, 0, 0, 0);
        check_head();
        fetch_ready = 0;
        @(posedge sysclk); #1;
        sysrst_n = 1'b1;
        run = 1;
        cyc("run_after_rst", 8'h00, 1, 1, 0);
        run = 0;
        // Stack must have been cleared: RET underflows
        redirect(2'd3, 8'h00);
        cyc("ret_after_rst", 8'h01, 1, 1, 1);
        br_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
